lfsr32_checker: RTL and testbench
=================================

// Module: lfsr32_checker
// PURPOSE
// - Receive-side PRBS checker for the 32-bit serial test stream (x^32+x^22+x^2+x^1+1 generator).
// - Self-synchronises to the incoming bitstream, flags bit errors, counts them, and declares lock/loss-of-lock.
// - Sits on the loopback/receive path of the serial test chain, one bit per qualified clock.
// PARAMETERS
// - LOCK_CNT   64   consecutive correct predictions required to enter LOCKED (>=1)
// - WIN_LEN    256  LOCKED-mode monitoring window length, in qualified bits (>=2)
// - ERR_THRESH 8    errors within one window that force loss of lock (1..WIN_LEN)
// - ERR_W      16   width of the saturating error counter
// PORTS
// - Clk       in   1      clock
// - ARst      in   1      reset, asynchronous, active-high
// - DIn       in   1      received serial bit
// - DInVld    in   1      DIn is qualified this cycle; all state advances only when high
// - ClrCnt    in   1      synchronous clear of ErrCnt (and BitCnt when present)
// - Locked    out  1      checker is in LOCKED state
// - ErrPulse  out  1      one-cycle pulse: the previous qualified bit mismatched while LOCKED
// - ErrCnt    out  ERR_W  saturating count of LOCKED-mode bit errors
// BEHAVIOUR
// - Sequence rule: b[n] = b[n-1]^b[n-2]^b[n-22]^b[n-32]; hist[31:0] holds b[n-1]..b[n-32], with hist[0]=b[n-1].
// - pred = hist[0]^hist[1]^hist[21]^hist[31]; mismatch = DIn^pred; evaluated only when DInVld=1.
// - Reset: state=SEARCH, hist=0, fill=0, match=0, win=0, werr=0; Locked=0, ErrPulse=0, ErrCnt=0.
// - SEARCH: shift DIn into hist each qualified bit; fill counter saturates at 32.
//   - With fill<32, or with hist all-zero, match clears to 0. Otherwise a match increments it and a mismatch clears it.
//   - The all-zero guard rejects a stuck-at-0 line.
//   - When match reaches LOCK_CNT -> LOCKED. Locked=1 the cycle after that bit. win=0, werr=0.
// - LOCKED (flywheel): shift pred, not DIn, into hist so one line error counts exactly once.
//   - A mismatch gives ErrPulse=1 next cycle, ErrCnt+1 (saturates at all-ones), werr+1.
//   - win counts qualified bits. At win==WIN_LEN-1, win and werr clear to 0.
//   - If this bit's error makes werr reach ERR_THRESH -> SEARCH next cycle: Locked=0, match=0, fill=0.
//   - The erroring bit still pulses ErrPulse and still counts.
//   - Threshold and window end on the same bit: loss of lock wins.
// - DInVld=0: no state, counter, or hist change; ErrPulse=0.
// - ClrCnt with a simultaneous error: clear wins, ErrCnt=0. ClrCnt does not affect lock state.
// - ARst mid-stream: everything returns to reset values immediately; relock needs >=32+LOCK_CNT qualified bits.
// - Latency: DIn sampled on edge k -> ErrPulse/ErrCnt/Locked updated on edge k+1. All outputs registered.
// CONFIGURATION
// - LFSR32_CHK_BITCNT_EN defined: adds output BitCnt[31:0].
//   - Counts qualified bits checked while LOCKED; wraps at 2^32; cleared by ARst and ClrCnt.
//   - Updates with the same latency as ErrCnt. Together with ErrCnt this gives BER.
// - LFSR32_CHK_BITCNT_EN not defined: port and counter absent; all other behaviour identical.
// TESTING
// - Clean stream from the generator (seed 1), DInVld=1 -> Locked=1 exactly 32+64 bits after the first bit; ErrCnt=0 after 10000 bits.
// - Locked, invert one bit at position 500 -> exactly one ErrPulse, ErrCnt=1, Locked stays 1.
// - Locked, invert 8 bits inside one 256-bit window -> ErrCnt=8, Locked=0 on the cycle after the 8th error; relocks after 96 clean bits.
// - DIn stuck at 0 for 1000 bits after reset -> Locked never asserts.
// - Clean stream with DInVld toggling every other cycle -> Locked after 96 qualified bits (192 clocks); ErrPulse never asserts.
// - ClrCnt with a simultaneous error, then ARst mid-lock -> ErrCnt=0, Locked=0 immediately; (BITCNT_EN) BitCnt=0 in both cases.

Source files
------------

// File: rtl/lfsr32_checker_if.sv
// lfsr32_checker_if: receive-stream and status bundle for the PRBS-32 checker.
// LFSR32_CHK_BITCNT_EN adds the BitCnt status field.
interface lfsr32_checker_if #(parameter int ERR_W = 16);
    logic             DIn;
    logic             DInVld;
    logic             ClrCnt;
    logic             Locked;
    logic             ErrPulse;
    logic [ERR_W-1:0] ErrCnt;
`ifdef LFSR32_CHK_BITCNT_EN
    logic [31:0]      BitCnt;
    modport master(output DIn, DInVld, ClrCnt, input Locked, ErrPulse, ErrCnt, BitCnt);
    modport slave(input DIn, DInVld, ClrCnt, output Locked, ErrPulse, ErrCnt, BitCnt);
`else
    modport master(output DIn, DInVld, ClrCnt, input Locked, ErrPulse, ErrCnt);
    modport slave(input DIn, DInVld, ClrCnt, output Locked, ErrPulse, ErrCnt);
`endif
endinterface

// File: rtl/lfsr32_checker.sv
// lfsr32_checker: self-synchronising x^32+x^22+x^2+x+1 PRBS checker with lock, error pulse and count.
// LFSR32_CHK_BITCNT_EN adds a 32-bit count of bits checked while locked.
module lfsr32_checker #(
    parameter int LOCK_CNT   = 64,
    parameter int WIN_LEN    = 256,
    parameter int ERR_THRESH = 8,
    parameter int ERR_W      = 16
) (
    input logic             Clk,
    input logic             ARst,
    lfsr32_checker_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(ERR_THRESH + 1);
    localparam logic [MW-1:0] LOCK_V   = MW'(LOCK_CNT);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] THR_LAST = EW'(ERR_THRESH - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [31:0]      hist_q, hist_d;
    logic [5:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_q, win_d;
    logic [EW-1:0]    werr_q, werr_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             pred, mis;
`ifdef LFSR32_CHK_BITCNT_EN
    logic [31:0]      bc_q, bc_d;
`endif

    assign pred = hist_q[0] ^ hist_q[1] ^ hist_q[21] ^ hist_q[31];
    assign mis  = bus.DIn ^ pred;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        cnt_d   = bus.ClrCnt ? '0 : cnt_q;
        if (bus.DInVld && state_q == SEARCH) begin
            hist_d  = {hist_q[30:0], bus.DIn};
            fill_d  = fill_q[5] ? fill_q : fill_q + 6'd1;
            match_d = (!fill_q[5] || hist_q == '0 || mis) ? '0 : match_q + 1'b1;
            if (match_d == LOCK_V) begin
                state_d = LOCKED;
                win_d   = '0;
                werr_d  = '0;
            end
        end else if (bus.DInVld) begin
            // Flywheel: predicted bit keeps the local LFSR aligned through line errors
            hist_d = {hist_q[30:0], pred};
            err_d  = mis;
            win_d  = win_q == WIN_LAST ? '0 : win_q + 1'b1;
            werr_d = win_q == WIN_LAST ? '0 : werr_q + EW'(mis);
            cnt_d  = (mis && !bus.ClrCnt && ~&cnt_q) ? cnt_q + 1'b1 : cnt_d;
            if (mis && werr_q == THR_LAST) begin
                state_d = SEARCH;
                match_d = '0;
                fill_d  = '0;
            end
        end
    end

`ifdef LFSR32_CHK_BITCNT_EN
    assign bc_d = bus.ClrCnt ? '0 : (bus.DInVld && state_q == LOCKED) ? bc_q + 32'd1 : bc_q;
    assign bus.BitCnt = bc_q;

    always_ff @(posedge Clk or posedge ARst)
        if (ARst) bc_q <= '0;
        else      bc_q <= bc_d;
`endif

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Locked   = state_q == LOCKED;
    assign bus.ErrPulse = err_q;
    assign bus.ErrCnt   = cnt_q;
endmodule

// File: tb/tb_lfsr32_checker.sv
// tb_lfsr32_checker: scoreboard bench driving a seed-1 PRBS-32 stream with injected errors,
// stuck line, gapped qualification, counter clear and asynchronous reset.
module tb_lfsr32_checker;
    logic Clk  = 1'b0;
    logic ARst = 1'b1;
    always #5 Clk = ~Clk;

    lfsr32_checker_if #(.ERR_W(16)) bus ();

    lfsr32_checker #(
        .LOCK_CNT(64), .WIN_LEN(256), .ERR_THRESH(8), .ERR_W(16)
    ) dut (
        .Clk(Clk), .ARst(ARst), .bus(bus)
    );

`ifdef LFSR32_CHK_BITCNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    typedef struct packed {
        logic        lk;
        logic        pulse;
        logic [15:0] cnt;
        logic [31:0] bc;
    } obs_t;

    obs_t        sb[$];
    int          checks = 0, failures = 0, pulses = 0;
    logic [31:0] gen = 32'h1;
    int          good, win, werr;
    logic        lk;
    logic [15:0] cnt;
    logic [31:0] bc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.lk    = bus.Locked;
        o.pulse = bus.ErrPulse;
        o.cnt   = bus.ErrCnt;
        o.bc    = 32'h0;
`ifdef LFSR32_CHK_BITCNT_EN
        o.bc    = bus.BitCnt;
`endif
        return o;
    endfunction

    task automatic model_reset();
        lk   = 1'b0;
        good = 0;
        win  = 0;
        werr = 0;
        cnt  = '0;
        bc   = '0;
    endtask

    // Asserted between edges: outputs must drop without waiting for a clock
    task automatic apply_reset(input string tag);
        ARst = 1'b1;
        #2;
        check_eq(tag, 64'(observe()), 64'(0));
        ARst = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit vld, input bit inv = 1'b0, input bit zero = 1'b0, input bit clr = 1'b0);
        logic b, p;
        obs_t e;
        b = gen[0] ^ gen[1] ^ gen[21] ^ gen[31];
        bus.DIn    = zero ? 1'b0 : b ^ inv;
        bus.DInVld = vld;
        bus.ClrCnt = clr;
        p = 1'b0;
        if (vld) begin
            if (lk) begin
                bc++;
                p = inv;
                if (inv) begin
                    werr++;
                    if (cnt != 16'hffff) cnt++;
                end
                if (inv && werr == 8) begin
                    lk   = 1'b0;
                    good = 0;
                end else if (win == 255) begin
                    win  = 0;
                    werr = 0;
                end else win++;
            end else begin
                good = zero ? 0 : good + 1;
                if (good == 96) begin
                    lk   = 1'b1;
                    win  = 0;
                    werr = 0;
                end
            end
            if (!zero) gen = {gen[30:0], b};
        end
        if (clr) begin
            cnt = '0;
            bc  = '0;
        end
        e.lk = lk; e.pulse = p; e.cnt = cnt; e.bc = BC_EN ? bc : 32'h0;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_eq("cycle", 64'(observe()), 64'(e));
        if (bus.ErrPulse) pulses++;
    endtask

    task automatic wait_win(input int target);
        for (int i = 0; i < 600 && win != target; i++) step(1'b1);
    endtask

    initial begin
        int first, q;
        logic seen;
        bus.DIn = 1'b0; bus.DInVld = 1'b0; bus.ClrCnt = 1'b0;
        model_reset();
        #3 check_eq("reset", 64'(observe()), 64'(0));
        @(posedge Clk);
        #1 ARst = 1'b0;

        first = 0;
        for (int i = 1; i <= 10000; i++) begin
            step(1'b1);
            if (first == 0 && bus.Locked) first = i;
        end
        check_eq("lock_at", first, 96);
        check_eq("clean_errcnt", bus.ErrCnt, 0);

        pulses = 0;
        for (int i = 1; i <= 800; i++) step(1'b1, i == 500);
        check_eq("single_pulses", pulses, 1);
        check_eq("single_cnt", bus.ErrCnt, 1);
        check_eq("single_locked", bus.Locked, 1);

        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("clr_cnt", bus.ErrCnt, 0);

        wait_win(10);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 9; j++) step(1'b1);
            step(1'b1, 1'b1);
        end
        check_eq("burst_unlock", bus.Locked, 0);
        check_eq("burst_cnt", bus.ErrCnt, 8);
        check_eq("burst_pulse", bus.ErrPulse, 1);

        first = 0;
        for (int i = 1; i <= 200; i++) begin
            step(1'b1);
            if (first == 0 && bus.Locked) first = i;
        end
        check_eq("relock_at", first, 96);

        // Eighth error on the last bit of a window: loss of lock must win
        wait_win(200);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
        wait_win(255);
        step(1'b1, 1'b1);
        check_eq("edge_unlock", bus.Locked, 0);
        check_eq("edge_cnt", bus.ErrCnt, 16);

        for (int i = 1; i <= 100; i++) step(1'b1);
        check_eq("relock2", bus.Locked, 1);
        wait_win(240);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
        wait_win(0);
        step(1'b1, 1'b1);
        check_eq("newwin_locked", bus.Locked, 1);
        check_eq("newwin_cnt", bus.ErrCnt, 24);

        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("clr_err_cnt", bus.ErrCnt, 0);
        check_eq("clr_err_pulse", bus.ErrPulse, 1);
        check_eq("clr_err_locked", bus.Locked, 1);
        for (int i = 0; i < 20; i++) step(1'b1);
        apply_reset("arst_midlock");

        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b1);
            seen |= bus.Locked;
        end
        check_eq("stuck_zero_lock", seen, 0);

        apply_reset("arst_restart");
        gen = 32'h1;
        pulses = 0;
        q = 0;
        first = 0;
        for (int c = 0; c < 400; c++) begin
            step(c % 2 == 0);
            if (c % 2 == 0) q++;
            if (first == 0 && bus.Locked) first = q;
        end
        check_eq("gapped_lock_at", first, 96);
        check_eq("gapped_pulses", pulses, 0);
        check_eq("gapped_cnt", bus.ErrCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
